// File: rtl/clock_pkg.sv
// Shared encodings, field widths and small helpers for the alarm clock datapath.
package clock_pkg;
  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HR_W    = 5;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  localparam logic [2:0] RUN     = 3'd0;
  localparam logic [2:0] SET_MIN = 3'd1;
  localparam logic [2:0] SET_HR  = 3'd2;
  localparam logic [2:0] ALM_MIN = 3'd3;
  localparam logic [2:0] ALM_HR  = 3'd4;
  localparam logic [2:0] RING    = 3'd5;

  typedef struct packed {
    logic time_min;
    logic time_hr;
    logic alm_min;
    logic alm_hr;
  } adj_t;

  // Any mode where a field is being edited (time or alarm).
  function automatic logic is_edit(input logic [2:0] m);
    return (m >= SET_MIN) && (m <= ALM_HR);
  endfunction

  // Time-set modes freeze the seconds counter.
  function automatic logic is_time_set(input logic [2:0] m);
    return (m == SET_MIN) || (m == SET_HR);
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: count wraps at TICK_DIV-1, tick flags the wrap cycle.
module tick_prescaler #(
  parameter int TICK_DIV = 100_000_000,
  localparam int CW = $clog2(TICK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  output logic          tick,
  output logic [CW-1:0] count
);
  assign tick = (count == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (clear || tick) count <= '0;
    else                    count <= count + CW'(1);
  end
endmodule

// File: rtl/alarm_clock_controller.sv
// Mode sequencer for the alarm clock: second enable, field adjust pulses,
// alarm arm/match and buzzer control. Every output is a flop.
module alarm_clock_controller import clock_pkg::*; #(
  parameter int TICK_DIV     = 100_000_000,
  parameter int RING_SECONDS = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_stop,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [HR_W-1:0]  cur_hr,
  input  logic [MIN_W-1:0] alm_min,
  input  logic [HR_W-1:0]  alm_hr,
  output logic             sec_en,
  output logic             sec_clr,
  output logic             updown,
  output logic             time_min_adj,
  output logic             time_hr_adj,
  output logic             alm_min_adj,
  output logic             alm_hr_adj,
  output logic [2:0]       mode,
  output logic             armed,
  output logic             buzzer,
  output logic             blink
);
  localparam int CW = $clog2(TICK_DIV);

  logic          tick, clear;
  logic [CW-1:0] pcnt, pcnt_nxt;
  logic [2:0]    mode_nxt;
  logic [5:0]    ring_cnt, ring_nxt;
  logic          armed_nxt, match, match_q, adj_req, ring_done, enter_set;
  adj_t          adj_nxt;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .tick  (tick),
    .count (pcnt)
  );

  always_comb begin
    match     = armed && (cur_hr == alm_hr) && (cur_min == alm_min) && (cur_sec == '0);
    ring_done = (mode == RING) && sec_en && (ring_cnt == 6'(RING_SECONDS - 1));
    adj_req   = btn_up ^ btn_down;
    mode_nxt  = mode;
    armed_nxt = armed;
    ring_nxt  = ring_cnt;
    adj_nxt   = '0;
    case (mode)
      // btn_mode beats a simultaneous alarm edge; that edge is then consumed.
      RUN:     if (btn_mode)                       mode_nxt = SET_MIN;
               else if (match && !match_q)         mode_nxt = RING;
               else if (btn_stop)                  armed_nxt = !armed;
      SET_MIN: if (btn_mode) mode_nxt = SET_HR;  else adj_nxt.time_min = adj_req;
      SET_HR:  if (btn_mode) mode_nxt = ALM_MIN; else adj_nxt.time_hr  = adj_req;
      ALM_MIN: if (btn_mode) mode_nxt = ALM_HR;  else adj_nxt.alm_min  = adj_req;
      ALM_HR:  if (btn_mode) mode_nxt = RUN;     else adj_nxt.alm_hr   = adj_req;
      RING: begin
        if (btn_stop || btn_mode || ring_done) begin
          mode_nxt = RUN;
          ring_nxt = '0;
        end else if (sec_en) begin
          ring_nxt = ring_cnt + 6'd1;
        end
      end
      default: mode_nxt = RUN;
    endcase
    if (adj_nxt.alm_min || adj_nxt.alm_hr) armed_nxt = 1'b1;
    enter_set = (mode == RUN) && (mode_nxt == SET_MIN);
    // Restart the second on entering and on leaving time set.
    clear     = enter_set || ((mode == SET_HR) && (mode_nxt != SET_HR));
    pcnt_nxt  = (clear || tick) ? '0 : pcnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode         <= RUN;
      armed        <= 1'b0;
      buzzer       <= 1'b0;
      ring_cnt     <= '0;
      match_q      <= 1'b0;
      sec_en       <= 1'b0;
      sec_clr      <= 1'b0;
      updown       <= 1'b1;
      time_min_adj <= 1'b0;
      time_hr_adj  <= 1'b0;
      alm_min_adj  <= 1'b0;
      alm_hr_adj   <= 1'b0;
      blink        <= 1'b1;
    end else begin
      mode         <= mode_nxt;
      armed        <= armed_nxt;
      buzzer       <= (mode_nxt == RING);
      ring_cnt     <= ring_nxt;
      match_q      <= match;
      sec_en       <= tick && !is_time_set(mode) && !is_time_set(mode_nxt);
      sec_clr      <= enter_set;
      if (|adj_nxt) updown <= btn_up;
      time_min_adj <= adj_nxt.time_min;
      time_hr_adj  <= adj_nxt.time_hr;
      alm_min_adj  <= adj_nxt.alm_min;
      alm_hr_adj   <= adj_nxt.alm_hr;
      // Phase-aligned with the prescaler value visible in the same cycle.
      blink        <= is_edit(mode_nxt) ? (pcnt_nxt < CW'(TICK_DIV / 2)) : 1'b1;
    end
  end
endmodule

// File: doc/alarm_clock_controller.md
Name: alarm_clock_controller

Overview:
- Central sequencer for the alarm clock datapath: produces the once-per-second enable for the seconds counter, runs the mode FSM (run / set time / set alarm / ringing), and issues single-cycle adjust pulses to the minute and hour counters.
- Detects the alarm match and drives the buzzer.
- Sits between the debounced button front-end and the seconds/minutes/hours/alarm registers.
- All outputs are registered.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per second tick (1 Hz from a 100 MHz clk); must be at least 4.
- RING_SECONDS, 60: sec_en pulses the buzzer stays on before auto-stop; range 1..63.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- btn_mode  in  1  debounced single-cycle pulse; advance mode
- btn_up  in  1  debounced pulse; increment selected field
- btn_down  in  1  debounced pulse; decrement selected field
- btn_stop  in  1  debounced pulse; stop ringing / toggle arm
- cur_sec  in  6  current seconds (0..59)
- cur_min  in  6  current minutes (0..59)
- cur_hr  in  5  current hours (0..23)
- alm_min  in  6  alarm minutes
- alm_hr  in  5  alarm hours
- sec_en  out  1  1-cycle pulse to the seconds counter enable
- sec_clr  out  1  1-cycle pulse clearing the seconds counter
- updown  out  1  direction qualifier for adj pulses (1 = up)
- time_min_adj  out  1  adjust pulse, time minutes
- time_hr_adj  out  1  adjust pulse, time hours
- alm_min_adj  out  1  adjust pulse, alarm minutes
- alm_hr_adj  out  1  adjust pulse, alarm hours
- mode  out  3  current FSM state encoding
- armed  out  1  alarm armed
- buzzer  out  1  buzzer drive
- blink  out  1  display blink for the field being edited

Behaviour:
- Reset values:
  - mode = RUN
  - all pulse outputs = 0
  - updown = 1, blink = 1
  - armed = 0, buzzer = 0
  - prescaler = 0, ring counter = 0
- Prescaler:
  - Free-running 0..TICK_DIV-1, wraps to 0.
  - tick = (prescaler == TICK_DIV-1).
  - sec_en is registered tick, so it is high for exactly one cycle after the wrap cycle.
  - sec_en is masked (held 0) in SET_MIN and SET_HR.
- Encodings and mode transitions:
  - RUN=0, SET_MIN=1, SET_HR=2, ALM_MIN=3, ALM_HR=4, RING=5.
  - On btn_mode: RUN->SET_MIN->SET_HR->ALM_MIN->ALM_HR->RUN.
- Entering SET_MIN:
  - sec_clr pulses one cycle.
  - Prescaler is forced to 0.
- Leaving SET_HR:
  - Prescaler is forced to 0, so the first sec_en occurs exactly TICK_DIV cycles after the exit.
- Adjust pulses:
  - In SET_MIN, SET_HR, ALM_MIN or ALM_HR, btn_up (or btn_down) produces the matching *_adj pulse next cycle, with updown = 1 (or 0) in the same cycle. Latency is 1 cycle.
  - btn_up and btn_down together: no pulse.
  - btn_mode together with up/down: the mode change wins and the adjust is dropped.
  - up/down in RUN or RING: ignored.
  - Any alm_*_adj pulse sets armed = 1.
- Arming:
  - btn_stop in RUN toggles armed.
  - btn_stop in the SET/ALM modes is ignored.
- Alarm match:
  - match = armed & cur_hr == alm_hr & cur_min == alm_min & cur_sec == 0.
  - RUN -> RING only on the rising edge of match (registered previous match), so the alarm fires once per minute boundary.
  - A match that occurs while in any SET/ALM mode is not latched.
- RING state:
  - buzzer = 1; sec_en continues.
  - The ring counter increments on each sec_en.
  - Exit to RUN (buzzer = 0, counter cleared) on btn_stop, on btn_mode, or when the counter reaches RING_SECONDS.
  - armed stays 1 after exit.
  - btn_stop and auto-timeout in the same cycle: single exit, no arm toggle.
- blink:
  - In SET/ALM modes, blink = (prescaler < TICK_DIV/2).
  - Otherwise blink = 1.
- Reset mid-operation: rst asserted in any state immediately returns all registers to their reset values; any pending pulse is lost.

Decomposition:
- Package clock_pkg holds:
  - mode encodings (RUN..RING, 3-bit)
  - widths SEC_W=6, MIN_W=6, HR_W=5
  - constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23
- One sub-module, tick_prescaler:
  - Ports: clk, rst, clear.
  - Outputs: tick and the count value (for blink).
  - Parameterised by TICK_DIV.
- The FSM, adjust logic and alarm match stay in alarm_clock_controller.

Test Plan:
- Tick rate (TICK_DIV=10): after reset in RUN, 50 cycles -> exactly 5 sec_en pulses, spaced 10 cycles; mode=0, buzzer=0, armed=0.
- Time set: btn_mode -> mode=1 with sec_clr pulse; 3x btn_up -> 3 time_min_adj pulses with updown=1, no sec_en while in SET_MIN; btn_mode -> mode=2; btn_down -> time_hr_adj with updown=0.
- Simultaneous buttons: btn_up+btn_down in SET_MIN -> no adj; btn_mode+btn_up in SET_MIN -> mode=2, no time_min_adj.
- Alarm fire and stop: set alarm via ALM modes (armed=1); drive cur_hr=7, cur_min=30, cur_sec=0 = alarm in RUN -> next cycle mode=5, buzzer=1; btn_stop -> mode=0, buzzer=0, armed=1; holding the match does not re-enter RING.
- Auto-timeout (RING_SECONDS=3, TICK_DIV=10): enter RING, no buttons -> buzzer clears after the 3rd sec_en, mode=0.
- Async reset: assert rst mid-RING between clock edges -> buzzer=0, mode=0, armed=0 immediately, without waiting for a clk edge.
